// File: rtl/ipml_prefetch_fifo_rd_unpack.sv
// Pops wide prefetch-FIFO words and replays them as c_RATIO narrow slices; slice 0 appears the cycle after the pop, and words follow each other with no idle cycle.
// out_rdy low freezes the current slice and blocks pops. Optional IPML_UNPACK_STAT_EN adds word_cnt and starve_cnt outputs.
module ipml_prefetch_fifo_rd_unpack #(
   parameter int c_IN_WIDTH  = 32,
   parameter int c_RATIO     = 4,
   parameter int c_LSB_FIRST = 1,
   localparam int c_OUT_WIDTH = c_IN_WIDTH / c_RATIO
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst,
   input  logic [c_IN_WIDTH-1:0]  fifo_rd_data,
   input  logic                   fifo_rd_vld,
   output logic                   fifo_rd_en,
   output logic [c_OUT_WIDTH-1:0] out_data,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic                   out_last,
   input  logic                   flush
`ifdef IPML_UNPACK_STAT_EN
   ,
   output logic [15:0]            word_cnt,
   output logic [15:0]            starve_cnt
`endif
);

   localparam int CW = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(c_RATIO - 1);

   logic [c_IN_WIDTH-1:0] hold_reg_q, hold_reg_d;
   logic                  hold_vld_q, hold_vld_d;
   logic [CW-1:0]         slice_cnt_q, slice_cnt_d;

   logic [c_RATIO-1:0][c_OUT_WIDTH-1:0] slices;
   logic [CW-1:0]         sel;
   logic                  last;
   logic                  beat;
   logic                  pop;

   assign slices     = hold_reg_q;
   assign last       = hold_vld_q & (slice_cnt_q == LAST_IDX);
   assign beat       = hold_vld_q & out_rdy;
   // Refill combinationally off out_rdy so the next word lands right behind the last slice.
   assign fifo_rd_en = ~rd_rst & ~flush & (~hold_vld_q | (out_rdy & last));
   assign pop        = fifo_rd_vld & fifo_rd_en;

   generate
      if (c_LSB_FIRST != 0) begin : g_lsb_first
         assign sel = slice_cnt_q;
      end else begin : g_msb_first
         assign sel = LAST_IDX - slice_cnt_q;
      end
   endgenerate

   assign out_data = slices[sel];
   assign out_vld  = hold_vld_q;
   assign out_last = last;

   always_comb begin
      hold_reg_d  = hold_reg_q;
      hold_vld_d  = hold_vld_q;
      slice_cnt_d = slice_cnt_q;
      if (flush) begin
         hold_vld_d  = 1'b0;
         slice_cnt_d = '0;
      end else if (pop) begin
         hold_reg_d  = fifo_rd_data;
         hold_vld_d  = 1'b1;
         slice_cnt_d = '0;
      end else if (beat && !last) begin
         slice_cnt_d = slice_cnt_q + CW'(1);
      end else if (beat && last) begin
         hold_vld_d  = 1'b0;
         slice_cnt_d = '0;
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         hold_reg_q  <= '0;
         hold_vld_q  <= 1'b0;
         slice_cnt_q <= '0;
      end else begin
         hold_reg_q  <= hold_reg_d;
         hold_vld_q  <= hold_vld_d;
         slice_cnt_q <= slice_cnt_d;
      end
   end

`ifdef IPML_UNPACK_STAT_EN
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [15:0] starve_cnt_q, starve_cnt_d;

   // Flush never clears the counters; a beat taken during flush still counts as a word end.
   always_comb begin
      word_cnt_d   = word_cnt_q;
      starve_cnt_d = starve_cnt_q;
      if (beat && last) begin
         word_cnt_d = word_cnt_q + 16'd1;
      end
      if (out_rdy && !hold_vld_q && (starve_cnt_q != 16'hFFFF)) begin
         starve_cnt_d = starve_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         word_cnt_q   <= '0;
         starve_cnt_q <= '0;
      end else begin
         word_cnt_q   <= word_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign word_cnt   = word_cnt_q;
   assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_ipml_prefetch_fifo_rd_unpack.sv
// Bench for ipml_prefetch_fifo_rd_unpack: LSB-first and MSB-first instances share one FIFO/stream stimulus and a slice-queue reference model.
module tb_ipml_prefetch_fifo_rd_unpack;
   localparam int IW = 32;
   localparam int R  = 4;
   localparam int OW = IW / R;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [IW-1:0] fdat = '0;
   logic          fvld = 1'b0;
   logic          flush = 1'b0;
   logic          rdy = 1'b0;
   logic          rd_en_l, rd_en_m, vld_l, vld_m, last_l, last_m;
   logic [OW-1:0] od_l, od_m;
`ifdef IPML_UNPACK_STAT_EN
   logic [15:0]   wc_l, sc_l, wc_m, sc_m;
`endif

   always #5 clk = ~clk;

   ipml_prefetch_fifo_rd_unpack #(.c_IN_WIDTH(IW), .c_RATIO(R), .c_LSB_FIRST(1)) dut_lsb (
      .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(fdat), .fifo_rd_vld(fvld), .fifo_rd_en(rd_en_l),
      .out_data(od_l), .out_vld(vld_l), .out_rdy(rdy), .out_last(last_l), .flush(flush)
`ifdef IPML_UNPACK_STAT_EN
      , .word_cnt(wc_l), .starve_cnt(sc_l)
`endif
   );

   ipml_prefetch_fifo_rd_unpack #(.c_IN_WIDTH(IW), .c_RATIO(R), .c_LSB_FIRST(0)) dut_msb (
      .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(fdat), .fifo_rd_vld(fvld), .fifo_rd_en(rd_en_m),
      .out_data(od_m), .out_vld(vld_m), .out_rdy(rdy), .out_last(last_m), .flush(flush)
`ifdef IPML_UNPACK_STAT_EN
      , .word_cnt(wc_m), .starve_cnt(sc_m)
`endif
   );

   int            errors = 0;
   int            checks = 0;
   logic [IW-1:0] fifo_q[$];
   logic [OW-1:0] exp_l[$];
   logic [OW-1:0] exp_m[$];
   int            m_words = 0;
   int            m_starve = 0;
   bit            hide = 1'b0;
   int            beats = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_l.delete();
      exp_m.delete();
      m_words  = 0;
      m_starve = 0;
   endtask

   // Word w split into R slices by plain shifting; MSB-first stream is the reverse order.
   task automatic model_push(input logic [IW-1:0] w);
      for (int i = 0; i < R; i++) begin
         exp_l.push_back(OW'(w >> (OW * i)));
         exp_m.push_back(OW'(w >> (OW * (R - 1 - i))));
      end
   endtask

   task automatic step(input bit r, input bit f);
      bit            ev, el, er, acc, pop;
      logic [IW-1:0] w;
      @(negedge clk);
      rdy   = r;
      flush = f;
      fvld  = (fifo_q.size() > 0) && !hide;
      if (fvld) fdat = fifo_q[0];
      else      fdat = IW'($urandom);
      #2;
      ev = (exp_l.size() > 0);
      el = (exp_l.size() == 1);
      er = !f && (!ev || (r && el));
      chk("vld_l", 32'(vld_l), 32'(ev));
      chk("vld_m", 32'(vld_m), 32'(ev));
      chk("last_l", 32'(last_l), 32'(el));
      chk("last_m", 32'(last_m), 32'(el));
      chk("rd_en_l", 32'(rd_en_l), 32'(er));
      chk("rd_en_m", 32'(rd_en_m), 32'(er));
      if (ev) begin
         chk("data_l", 32'(od_l), 32'(exp_l[0]));
         chk("data_m", 32'(od_m), 32'(exp_m[0]));
      end
`ifdef IPML_UNPACK_STAT_EN
      chk("word_cnt", 32'(wc_l), 32'(m_words & 16'hFFFF));
      chk("starve_cnt", 32'(sc_l), 32'(m_starve));
      chk("word_cnt_m", 32'(wc_m), 32'(m_words & 16'hFFFF));
`endif
      if (vld_l && r) beats++;
      acc = ev && r;
      pop = er && fvld;
      if (acc && el) m_words++;
      if (r && !ev && m_starve < 65535) m_starve++;
      if (f) begin
         exp_l.delete();
         exp_m.delete();
      end else begin
         if (acc) begin
            void'(exp_l.pop_front());
            void'(exp_m.pop_front());
         end
         if (pop) begin
            w = fifo_q.pop_front();
            model_push(w);
         end
      end
      @(posedge clk);
   endtask

   // Asynchronous reset raised mid-cycle; outputs must drop before any clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rdy   = 1'b0;
      flush = 1'b0;
      fvld  = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk({tag, "_vld"}, 32'(vld_l | vld_m), 32'd0);
      chk({tag, "_last"}, 32'(last_l | last_m), 32'd0);
      chk({tag, "_rd_en"}, 32'(rd_en_l | rd_en_m), 32'd0);
      chk({tag, "_data"}, 32'({od_l, od_m}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (fifo_q.size() > 0 || exp_l.size() > 0); i++) step(1'b1, 1'b0);
      chk("drain_done", 32'(fifo_q.size() + exp_l.size()), 32'd0);
   endtask

   initial begin
      do_reset("reset");

      // Two back-to-back words, sink always ready.
      fifo_q.push_back(32'hDDCC_BBAA);
      fifo_q.push_back(32'h4433_2211);
      beats = 0;
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
      chk("t1_beats", 32'(beats), 32'd8);

      // Backpressure mid-word: BB held for three cycles.
      fifo_q.push_back(32'hDDCC_BBAA);
      beats = 0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      chk("t3_beats", 32'(beats), 32'd4);

      // Flush while slice 1 is presented, with a second word waiting.
      fifo_q.push_back(32'hDDCC_BBAA);
      fifo_q.push_back(32'h4433_2211);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      drain();

      // Randomized traffic: FIFO gaps, backpressure and occasional flush.
      for (int i = 0; i < 400; i++) begin
         if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) fifo_q.push_back(IW'($urandom));
         hide = ($urandom_range(0, 7) == 0);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      hide = 1'b0;
      drain();

      // Reset mid-word: the next popped word restarts at slice 0.
      fifo_q.push_back(32'hDDCC_BBAA);
      fifo_q.push_back(32'h4433_2211);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      do_reset("midrst");
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      drain();

`ifdef IPML_UNPACK_STAT_EN
      do_reset("statrst");
      fifo_q.push_back(32'h0102_0304);
      fifo_q.push_back(32'h0506_0708);
      fifo_q.push_back(32'h090A_0B0C);
      for (int i = 0; i < 18; i++) step(1'b1, 1'b0);
      @(negedge clk);
      rdy = 1'b0;
      #2;
      chk("stat_words", 32'(wc_l), 32'd3);
      chk("stat_starve", 32'(sc_l), 32'd6);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
